uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single UART transmit stream (to_uart_* sink of the UART core) between NUM_REQ requesters.
//   Round-robin arbitration with message locking: a grant is held until the requester's last byte is accepted.
//   A stall watchdog releases a grant whose owner goes silent mid-message.
//   Sits between system producers (echo path, status reporter, debug dumper) and the UART core TX sink.
// PARAMETERS
//   NUM_REQ   4    number of requesters, 2..8
//   TIMEOUT   1024 cycles of owner silence (valid low, mid-message) before forced release; 0 disables the watchdog
// PORTS
//   clk            in   1          system clock; all logic rising-edge
//   reset          in   1          asynchronous, active-low reset (0 = reset asserted)
//   req_valid      in   NUM_REQ    per-requester byte valid
//   req_data       in   8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
//   req_last       in   NUM_REQ    byte is the final byte of the message
//   req_ready      out  NUM_REQ    per-requester accept
//   to_uart_data   out  8          byte to UART core
//   to_uart_error  out  1          tied 0
//   to_uart_valid  out  1          byte valid to UART core
//   to_uart_ready  in   1          UART core accepts byte
//   grant_id       out  3          index of current owner; valid while busy=1
//   busy           out  1          1 while a grant is held (LOCKED)
//   timeout_pulse  out  1          one-cycle pulse when the watchdog forces a release
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has top priority first), grant_id=0, busy=0,
//     timeout count=0, timeout_pulse=0. All outputs 0 while reset is asserted.
//   States: IDLE, LOCKED.
//   IDLE: to_uart_valid=0, all req_ready=0.
//     If any req_valid is high, pick the first requester set when searching rr_ptr+1, rr_ptr+2, ...,
//     wrapping modulo NUM_REQ. Register it into grant_id and go to LOCKED on the next edge.
//     Arbitration latency: exactly 1 cycle.
//   LOCKED, owner g:
//     to_uart_valid=req_valid[g], to_uart_data=req_data[g]. These are combinational; no added latency.
//     req_ready[g]=to_uart_ready. Every other req_ready is 0.
//     A transfer occurs when req_valid[g] & to_uart_ready.
//     Transfer with req_last[g]=1: go to IDLE next cycle and set rr_ptr=g.
//     Min gap between messages is 1 idle cycle (the arbitration cycle).
//     Requesters must hold valid/data/last stable until the transfer.
//   Watchdog (TIMEOUT>0):
//     Counter cnt, width $clog2(TIMEOUT+1), saturating. Cleared on entry to LOCKED and on every transfer.
//     Increments each LOCKED cycle with req_valid[g]=0.
//     Holds (no increment) when req_valid[g]=1 and to_uart_ready=0; UART backpressure never times out.
//     When cnt reaches TIMEOUT: go to IDLE, set rr_ptr=g, pulse timeout_pulse for 1 cycle.
//     The message is truncated; no byte is injected.
//   Simultaneous events: a transfer on the cycle cnt would reach TIMEOUT wins; the counter clears, no pulse.
//   Owner and non-owner valids: non-owners are ignored while LOCKED and are considered at the next IDLE cycle.
//   Reset mid-message: immediate return to reset values. The UART core may have partially sent bytes;
//     no recovery is attempted.
//   to_uart_error is constant 0.
// STRUCTURE
//   Package uart_arb_pkg:
//     state typedef (IDLE, LOCKED), MAX_REQ=8, GRANT_W=3, BYTE_W=8.
//   Sub-module rr_picker:
//     Combinational. Inputs req[NUM_REQ] and ptr. Outputs found and idx (first set bit after ptr, wrapping).
//   Top holds the FSM, grant/ptr registers, output mux and watchdog counter.
// TESTING
//   1. After reset, req_valid=4'b0001, 3-byte message 0x41,0x42,0x43 (last on 0x43), to_uart_ready=1:
//      busy rises 1 cycle after valid; 3 consecutive transfers; busy falls; grant_id=0 during message.
//   2. All four valid with 1-byte messages each, kept re-requesting:
//      grant order 0,1,2,3,0; one IDLE cycle between grants.
//   3. Owner 2 mid-message, to_uart_ready held 0 for 5000 cycles:
//      no timeout_pulse; data held stable; resumes when ready=1.
//   4. TIMEOUT=16, owner 1 drops valid after its first byte:
//      timeout_pulse exactly 16 cycles after the last transfer; busy=0; next grant goes to 2 if requesting.
//   5. Owner transfers a byte on the cycle cnt=TIMEOUT-1:
//      no pulse; counter clears; message continues.
//   6. reset=0 asserted during a message:
//      busy, req_ready, to_uart_valid go 0 immediately; after release, requester 0 wins a 4-way contention.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e : arbiter FSM state (idle / locked to one owner)
//   MAX_REQ     : largest supported requester count
//   GRANT_W     : width of a requester index
//   BYTE_W      : width of one transmitted byte
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned GRANT_W = 3;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search.
//   req   : request vector, one bit per requester
//   ptr   : index of the most recently served requester
//   found : at least one request is set
//   idx   : first set request after ptr, searching upward and wrapping
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               found,
  output logic [GRANT_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // ptr itself is visited last, so the previous owner has lowest priority.
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      int pos;
      pos = (int'(ptr) + k) % int'(NUM_REQ);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = GRANT_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit sink between NUM_REQ byte-stream requesters.
// Round-robin arbitration, grant held until the owner's last byte is accepted; a
// watchdog releases an owner that stops presenting bytes mid-message.
//   clk, reset (async, active-low)
//   req_valid/req_data/req_last/req_ready : per-requester byte streams
//   to_uart_data/valid/ready/error        : stream into the UART core
//   grant_id, busy                        : current owner, valid while busy
//   timeout_pulse                         : one-cycle flag on a watchdog release
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]           to_uart_data,
  output logic                        to_uart_error,
  output logic                        to_uart_valid,
  input  logic                        to_uart_ready,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        busy,
  output logic                        timeout_pulse
);

  localparam bit          WdEn = (TIMEOUT > 0);
  localparam int unsigned CntW = WdEn ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  arb_state_e         state_q;
  logic [GRANT_W-1:0] grant_q;
  logic [GRANT_W-1:0] ptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               timeout_q;

  logic               found;
  logic [GRANT_W-1:0] pick;
  logic               locked;
  logic               owner_valid;
  logic               owner_last;
  logic [BYTE_W-1:0]  owner_data;
  logic               xfer;
  logic               wd_expire;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req  (req_valid),
    .ptr  (ptr_q),
    .found(found),
    .idx  (pick)
  );

  assign locked = (state_q == StLocked);

  // Owner mux and per-requester ready steering.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    req_ready   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == GRANT_W'(i)) begin
        owner_valid  = req_valid[i];
        owner_last   = req_last[i];
        owner_data   = req_data[BYTE_W*i +: BYTE_W];
        req_ready[i] = locked & to_uart_ready;
      end
    end
  end

  assign xfer = locked & owner_valid & to_uart_ready;
  // Fires on the silent cycle that would bring the count to TIMEOUT; a transfer
  // on that cycle takes precedence.
  assign wd_expire = WdEn & locked & ~owner_valid & (cnt_q == CntLast);

  assign to_uart_valid = locked & owner_valid;
  assign to_uart_data  = locked ? owner_data : '0;
  assign to_uart_error = 1'b0;
  assign grant_id      = grant_q;
  assign busy          = locked;
  assign timeout_pulse = timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= GRANT_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q <= pick;
            cnt_q   <= '0;
            state_q <= StLocked;
          end
        end
        StLocked: begin
          if (xfer) begin
            cnt_q <= '0;
            if (owner_last) begin
              ptr_q   <= grant_q;
              state_q <= StIdle;
            end
          end else if (wd_expire) begin
            cnt_q     <= '0;
            ptr_q     <= grant_q;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else if (WdEn && !owner_valid && cnt_q != CntMax) begin
            // Backpressure (owner valid, sink not ready) holds the count.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=16).
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [7:0]    to_uart_data;
  logic          to_uart_error;
  logic          to_uart_valid;
  logic          to_uart_ready;
  logic [2:0]    grant_id;
  logic          busy;
  logic          timeout_pulse;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .to_uart_data (to_uart_data),
    .to_uart_error(to_uart_error),
    .to_uart_valid(to_uart_valid),
    .to_uart_ready(to_uart_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    to_uart_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic saw_pulse;
    logic lost_busy;
    logic data_moved;

    // Reset values.
    do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_ready", {28'b0, req_ready}, 0);
    check_eq("rst_valid", {31'b0, to_uart_valid}, 0);
    check_eq("rst_grant", {29'b0, grant_id}, 0);
    check_eq("rst_pulse", {31'b0, timeout_pulse}, 0);
    check_eq("rst_err", {31'b0, to_uart_error}, 0);
    reset = 1'b1;
    tick();

    // 1: three-byte message from requester 0.
    set_req(0, 1'b1, 8'h41, 1'b0);
    #1;
    check_eq("t1_arb_busy", {31'b0, busy}, 0);
    check_eq("t1_arb_ready", {28'b0, req_ready}, 0);
    tick();
    check_eq("t1_busy", {31'b0, busy}, 1);
    check_eq("t1_grant", {29'b0, grant_id}, 0);
    check_eq("t1_ready", {28'b0, req_ready}, 32'h1);
    check_eq("t1_d0", {24'b0, to_uart_data}, 32'h41);
    tick();
    set_req(0, 1'b1, 8'h42, 1'b0);
    #1;
    check_eq("t1_d1", {24'b0, to_uart_data}, 32'h42);
    check_eq("t1_busy1", {31'b0, busy}, 1);
    tick();
    set_req(0, 1'b1, 8'h43, 1'b1);
    #1;
    check_eq("t1_d2", {24'b0, to_uart_data}, 32'h43);
    check_eq("t1_v2", {31'b0, to_uart_valid}, 1);
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    #1;
    check_eq("t1_done_busy", {31'b0, busy}, 0);
    check_eq("t1_done_valid", {31'b0, to_uart_valid}, 0);

    // 2: four requesters, one-byte messages, continuously requesting.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("t2_busy%0d", k), {31'b0, busy}, 1);
      check_eq($sformatf("t2_grant%0d", k), {29'b0, grant_id}, 32'(exp_order[k]));
      check_eq($sformatf("t2_data%0d", k), {24'b0, to_uart_data}, 32'(8'h10 + exp_order[k]));
      tick();
      check_eq($sformatf("t2_gap%0d", k), {31'b0, busy}, 0);
    end

    // 3: owner 2 stalled by UART backpressure for 5000 cycles.
    do_reset();
    set_req(2, 1'b1, 8'h55, 1'b0);
    tick();
    check_eq("t3_grant", {29'b0, grant_id}, 2);
    check_eq("t3_ready", {28'b0, req_ready}, 32'h4);
    tick();
    set_req(2, 1'b1, 8'h66, 1'b1);
    to_uart_ready = 1'b0;
    saw_pulse = 1'b0;
    lost_busy = 1'b0;
    data_moved = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      if (timeout_pulse) saw_pulse = 1'b1;
      if (!busy) lost_busy = 1'b1;
      if (to_uart_data != 8'h66 || !to_uart_valid) data_moved = 1'b1;
    end
    check_eq("t3_no_pulse", {31'b0, saw_pulse}, 0);
    check_eq("t3_held", {31'b0, lost_busy}, 0);
    check_eq("t3_stable", {31'b0, data_moved}, 0);
    check_eq("t3_stall_ready", {28'b0, req_ready}, 0);
    to_uart_ready = 1'b1;
    #1;
    check_eq("t3_resume_ready", {28'b0, req_ready}, 32'h4);
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    #1;
    check_eq("t3_end_busy", {31'b0, busy}, 0);

    // 4: owner 1 goes silent after one byte; watchdog releases after 16 cycles.
    do_reset();
    set_req(1, 1'b1, 8'h71, 1'b0);
    tick();
    check_eq("t4_grant", {29'b0, grant_id}, 1);
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b1, 8'h72, 1'b1);
    saw_pulse = 1'b0;
    lost_busy = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (timeout_pulse) saw_pulse = 1'b1;
      if (!busy) lost_busy = 1'b1;
    end
    check_eq("t4_early_pulse", {31'b0, saw_pulse}, 0);
    check_eq("t4_early_release", {31'b0, lost_busy}, 0);
    tick();
    check_eq("t4_pulse", {31'b0, timeout_pulse}, 1);
    check_eq("t4_busy", {31'b0, busy}, 0);
    tick();
    check_eq("t4_pulse_once", {31'b0, timeout_pulse}, 0);
    check_eq("t4_next_grant", {29'b0, grant_id}, 2);
    check_eq("t4_next_busy", {31'b0, busy}, 1);

    // 5: transfer on the cycle the count sits at TIMEOUT-1 clears the watchdog.
    do_reset();
    set_req(1, 1'b1, 8'h81, 1'b0);
    tick();
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    set_req(1, 1'b1, 8'h82, 1'b0);
    tick();
    check_eq("t5_no_pulse", {31'b0, timeout_pulse}, 0);
    check_eq("t5_busy", {31'b0, busy}, 1);
    set_req(1, 1'b0, 8'h00, 1'b0);
    saw_pulse = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (timeout_pulse || !busy) saw_pulse = 1'b1;
    end
    check_eq("t5_cleared", {31'b0, saw_pulse}, 0);
    set_req(1, 1'b1, 8'h83, 1'b1);
    tick();
    check_eq("t5_end_busy", {31'b0, busy}, 0);
    check_eq("t5_end_pulse", {31'b0, timeout_pulse}, 0);

    // 6: reset asserted mid-message, then 4-way contention.
    do_reset();
    set_req(0, 1'b1, 8'h91, 1'b0);
    tick();
    tick();
    set_req(0, 1'b1, 8'h92, 1'b0);
    #1;
    check_eq("t6_pre_busy", {31'b0, busy}, 1);
    reset = 1'b0;
    #1;
    check_eq("t6_busy", {31'b0, busy}, 0);
    check_eq("t6_ready", {28'b0, req_ready}, 0);
    check_eq("t6_valid", {31'b0, to_uart_valid}, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'hA0 + i), 1'b1);
    tick();
    check_eq("t6_grant", {29'b0, grant_id}, 0);
    check_eq("t6_data", {24'b0, to_uart_data}, 32'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
